// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer write path: screen geometry,
// the {Y,X} address packing and the fill FSM state encoding.
package fb_pkg;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  // Frame buffer address is the row in the upper bits, the column in the lower 8.
  function automatic logic [14:0] fb_pack(input logic [7:0] x, input logic [6:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_rect_scanner.sv
// Raster walker for the rectangle fill engine. It loads the rectangle bounds on
// start, steps left-to-right then top-to-bottom on each advance, and flags the
// bottom-right corner so the controller knows which write is the last one.
module fb_rect_scanner
  import fb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_x0,
  input  logic [7:0] i_x1,
  input  logic [6:0] i_y0,
  input  logic [6:0] i_y1,
  input  logic       i_advance,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_last
);

  logic [7:0] r_x0;
  logic [7:0] r_x1;
  logic [6:0] r_y1;
  logic [7:0] r_x;
  logic [6:0] r_y;

  // Load the bounds on start, otherwise walk the raster one pixel per advance.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_start) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_advance) begin
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_x1) && (r_y == r_y1);

endmodule

// File: rtl/fb_write_arbiter.sv
// Owner of the frame buffer write port. Arbitrates between single-pixel CPU
// writes and the rectangle fill engine. The CPU normally wins, but after
// CPU_BURST back-to-back CPU grants a pending fill is guaranteed one slot.
// Every output is registered, so a request seen at one edge is visible on the
// frame buffer port right after that edge.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int X_MAX     = FB_W - 1,
  parameter int Y_MAX     = FB_H - 1,
  parameter int CPU_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic [7:0]  i_cpu_x,
  input  logic [6:0]  i_cpu_y,
  input  logic        i_cpu_pixel,
  output logic        o_cpu_gnt,
  input  logic        i_fill_start,
  input  logic [7:0]  i_fill_x0,
  input  logic [7:0]  i_fill_x1,
  input  logic [6:0]  i_fill_y0,
  input  logic [6:0]  i_fill_y1,
  input  logic        i_fill_pixel,
  output logic        o_fill_busy,
  output logic        o_fill_done,
  output logic        o_fill_err,
  output logic [14:0] o_fb_addr,
  output logic        o_fb_data_in,
  output logic        o_fb_we
);

  localparam int              BURST_W = $clog2(CPU_BURST + 1);
  localparam logic [BURST_W-1:0] L_BURST = BURST_W'(CPU_BURST);
  localparam logic [7:0]      L_X_MAX = 8'(X_MAX);
  localparam logic [6:0]      L_Y_MAX = 7'(Y_MAX);

  fill_state_t         r_state;
  fill_state_t         w_state_next;
  logic [BURST_W-1:0]  r_burst;
  logic [BURST_W-1:0]  w_burst_next;
  logic                r_fill_pixel;

  logic                r_cpu_gnt;
  logic                r_fill_busy;
  logic                r_fill_done;
  logic                r_fill_err;
  logic [14:0]         r_fb_addr;
  logic                r_fb_data;
  logic                r_fb_we;

  logic                w_cpu_gnt_d;
  logic                w_fill_busy_d;
  logic                w_fill_done_d;
  logic                w_fill_err_d;
  logic [14:0]         w_fb_addr_d;
  logic                w_fb_data_d;
  logic                w_fb_we_d;

  logic                w_start_seen;
  logic                w_cmd_ok;
  logic                w_accept;
  logic                w_reject;
  logic                w_fill_slot;
  logic                w_cpu_win;
  logic                w_cpu_in_range;

  logic [7:0]          w_scan_x;
  logic [6:0]          w_scan_y;
  logic                w_scan_last;

  // A start command only counts in IDLE; a command is legal when both ranges
  // are ordered and lie on screen, which also rules out counter wrap.
  assign w_start_seen   = i_fill_start && (r_state == IDLE);
  assign w_cmd_ok       = (i_fill_x0 <= i_fill_x1) && (i_fill_y0 <= i_fill_y1) &&
                          (i_fill_x1 <= L_X_MAX) && (i_fill_y1 <= L_Y_MAX);
  assign w_accept       = w_start_seen && w_cmd_ok;
  assign w_reject       = w_start_seen && !w_cmd_ok;

  // The fill takes the port whenever the CPU is quiet or its burst allowance is used up.
  assign w_fill_slot    = (r_state == FILL) && (!i_cpu_req || (r_burst == L_BURST));
  assign w_cpu_win      = i_cpu_req && !w_fill_slot;
  assign w_cpu_in_range = (i_cpu_x <= L_X_MAX) && (i_cpu_y <= L_Y_MAX);

  fb_rect_scanner u_scanner (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_accept),
    .i_x0      (i_fill_x0),
    .i_x1      (i_fill_x1),
    .i_y0      (i_fill_y0),
    .i_y1      (i_fill_y1),
    .i_advance (w_fill_slot),
    .o_x       (w_scan_x),
    .o_y       (w_scan_y),
    .o_last    (w_scan_last)
  );

  // State, burst counter and latched fill value.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_burst      <= '0;
      r_fill_pixel <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_burst <= w_burst_next;
      if (w_accept) begin
        r_fill_pixel <= i_fill_pixel;
      end
    end
  end

  // Next state: accepted commands fill, rejected ones go straight to DONE,
  // and the fill ends on the cycle it writes the bottom-right pixel.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = FILL;
        end else if (w_reject) begin
          w_state_next = DONE;
        end
      end
      FILL: begin
        if (w_fill_slot && w_scan_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of every registered output plus the CPU burst count.
  always_comb begin
    w_cpu_gnt_d   = 1'b0;
    w_fb_we_d     = 1'b0;
    w_fb_addr_d   = r_fb_addr;
    w_fb_data_d   = r_fb_data;
    w_fill_busy_d = (w_state_next == FILL);
    w_fill_done_d = (r_state == DONE);
    w_fill_err_d  = r_fill_err;
    w_burst_next  = '0;

    if (w_fill_slot) begin
      w_fb_we_d   = 1'b1;
      w_fb_addr_d = fb_pack(w_scan_x, w_scan_y);
      w_fb_data_d = r_fill_pixel;
    end else if (w_cpu_win) begin
      w_cpu_gnt_d = 1'b1;
      w_fb_we_d   = w_cpu_in_range;
      w_fb_addr_d = fb_pack(i_cpu_x, i_cpu_y);
      w_fb_data_d = i_cpu_pixel;
      if (r_state == FILL) begin
        w_burst_next = r_burst + 1'b1;
      end
    end

    if (w_accept) begin
      w_fill_err_d = 1'b0;
    end else if (w_reject) begin
      w_fill_err_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cpu_gnt   <= 1'b0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_err  <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= 1'b0;
      r_fb_we     <= 1'b0;
    end else begin
      r_cpu_gnt   <= w_cpu_gnt_d;
      r_fill_busy <= w_fill_busy_d;
      r_fill_done <= w_fill_done_d;
      r_fill_err  <= w_fill_err_d;
      r_fb_addr   <= w_fb_addr_d;
      r_fb_data   <= w_fb_data_d;
      r_fb_we     <= w_fb_we_d;
    end
  end

  assign o_cpu_gnt    = r_cpu_gnt;
  assign o_fill_busy  = r_fill_busy;
  assign o_fill_done  = r_fill_done;
  assign o_fill_err   = r_fill_err;
  assign o_fb_addr    = r_fb_addr;
  assign o_fb_data_in = r_fb_data;
  assign o_fb_we      = r_fb_we;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for the frame buffer write arbiter. Every expected frame buffer write
// goes into a queue when its stimulus is driven; a monitor pops and compares
// each write the DUT actually issues.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        cpuReq;
  logic [7:0]  cpuX;
  logic [6:0]  cpuY;
  logic        cpuPixel;
  logic        cpuGnt;
  logic        fillStart;
  logic [7:0]  fillX0, fillX1;
  logic [6:0]  fillY0, fillY1;
  logic        fillPixel;
  logic        fillBusy, fillDone, fillErr;
  logic [14:0] fbAddr;
  logic        fbData, fbWe;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic        data;
  } wr_t;

  wr_t         expQ[$];
  logic [14:0] lastAddr = '0;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic        pix;
    logic        expWe;
    logic [14:0] expAddr;
  } cpu_vec_t;

  fb_write_arbiter dut (
    .i_clk        (clk),
    .i_reset      (resetN),
    .i_cpu_req    (cpuReq),
    .i_cpu_x      (cpuX),
    .i_cpu_y      (cpuY),
    .i_cpu_pixel  (cpuPixel),
    .o_cpu_gnt    (cpuGnt),
    .i_fill_start (fillStart),
    .i_fill_x0    (fillX0),
    .i_fill_x1    (fillX1),
    .i_fill_y0    (fillY0),
    .i_fill_y1    (fillY1),
    .i_fill_pixel (fillPixel),
    .o_fill_busy  (fillBusy),
    .o_fill_done  (fillDone),
    .o_fill_err   (fillErr),
    .o_fb_addr    (fbAddr),
    .o_fb_data_in (fbData),
    .o_fb_we      (fbWe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every write the DUT issues must match the head of the expected queue.
  always @(negedge clk) begin
    if (fbWe === 1'b1) begin
      lastAddr = fbAddr;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {16'h0, fbAddr, fbData}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", {17'h0, fbAddr}, {17'h0, e.addr});
        checkOutput("write_data", {31'h0, fbData}, {31'h0, e.data});
      end
    end
  end

  task automatic pushFill(input int x0, input int x1, input int y0, input int y1,
                          input logic pix, input int maxCount);
    int n = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (n < maxCount) expQ.push_back({15'(y * 256 + x), pix});
        n++;
      end
    end
  endtask

  task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                               input logic pix);
    fillX0    = 8'(x0);
    fillX1    = 8'(x1);
    fillY0    = 7'(y0);
    fillY1    = 7'(y1);
    fillPixel = pix;
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
  endtask

  // Launch a fill, count busy cycles and done pulses until shortly after done.
  // midAt >= 0 fires a second, conflicting start that cycle.
  task automatic runFill(input int x0, input int x1, input int y0, input int y1,
                         input logic pix, input int limit, input int midAt,
                         output int busyCnt, output int doneCnt);
    int  post = 0;
    int  c    = 0;
    bit  fin  = 0;
    if (x0 <= x1 && y0 <= y1 && x1 <= 159 && y1 <= 119)
      pushFill(x0, x1, y0, y1, pix, 1 << 30);
    applyStimulus(x0, x1, y0, y1, pix);
    busyCnt = 0;
    doneCnt = 0;
    while (!fin && c < limit) begin
      if (fillBusy) busyCnt++;
      if (fillDone) doneCnt++;
      if (doneCnt > 0) begin
        post++;
        if (post > 3) fin = 1;
      end
      fillStart = (c == midAt);
      if (c == midAt) begin
        fillX0 = 8'd0; fillX1 = 8'd0; fillY0 = 7'd0; fillY1 = 7'd0; fillPixel = 1'b1;
      end
      tick();
      c++;
    end
    fillStart = 1'b0;
    if (!fin) checkOutput("fill_timeout", 32'(c), 32'(limit + 1));
  endtask

  cpu_vec_t vecs[6];

  initial begin
    int busyCnt, doneCnt, gnts, writes;
    bit seen;

    vecs[0] = '{x: 8'd10,  y: 7'd20,  pix: 1'b1, expWe: 1'b1, expAddr: 15'h140A};
    vecs[1] = '{x: 8'd0,   y: 7'd0,   pix: 1'b0, expWe: 1'b1, expAddr: 15'h0000};
    vecs[2] = '{x: 8'd159, y: 7'd119, pix: 1'b1, expWe: 1'b1, expAddr: 15'h779F};
    vecs[3] = '{x: 8'd160, y: 7'd0,   pix: 1'b1, expWe: 1'b0, expAddr: 15'h0000};
    vecs[4] = '{x: 8'd0,   y: 7'd120, pix: 1'b0, expWe: 1'b0, expAddr: 15'h0000};
    vecs[5] = '{x: 8'd255, y: 7'd127, pix: 1'b1, expWe: 1'b0, expAddr: 15'h0000};

    resetN = 1'b0; cpuReq = 1'b0; cpuX = '0; cpuY = '0; cpuPixel = 1'b0;
    fillStart = 1'b0; fillX0 = '0; fillX1 = '0; fillY0 = '0; fillY1 = '0; fillPixel = 1'b0;
    repeat (3) tick();
    checkOutput("rst_we",   {31'h0, fbWe},     0);
    checkOutput("rst_addr", {17'h0, fbAddr},   0);
    checkOutput("rst_data", {31'h0, fbData},   0);
    checkOutput("rst_gnt",  {31'h0, cpuGnt},   0);
    checkOutput("rst_busy", {31'h0, fillBusy}, 0);
    checkOutput("rst_done", {31'h0, fillDone}, 0);
    checkOutput("rst_err",  {31'h0, fillErr},  0);
    resetN = 1'b1;
    tick();

    // Single CPU writes in IDLE, in range and off screen.
    for (int i = 0; i < 6; i++) begin
      cpuReq = 1'b1; cpuX = vecs[i].x; cpuY = vecs[i].y; cpuPixel = vecs[i].pix;
      if (vecs[i].expWe) expQ.push_back({vecs[i].expAddr, vecs[i].pix});
      tick();
      cpuReq = 1'b0;
      checkOutput($sformatf("cpu_gnt[%0d]", i), {31'h0, cpuGnt}, 1);
      checkOutput($sformatf("cpu_we[%0d]", i),  {31'h0, fbWe},   {31'h0, vecs[i].expWe});
      tick();
      checkOutput($sformatf("cpu_gnt_off[%0d]", i), {31'h0, cpuGnt}, 0);
    end

    // Small fill with no CPU traffic.
    runFill(0, 2, 0, 1, 1'b1, 40, -1, busyCnt, doneCnt);
    checkOutput("fill6_busy", 32'(busyCnt), 6);
    checkOutput("fill6_done", 32'(doneCnt), 1);
    checkOutput("fill6_q",    32'(expQ.size()), 0);

    // Single-pixel fill under a held CPU request: four CPU slots, then the fill.
    cpuX = 8'd1; cpuY = 7'd1; cpuPixel = 1'b0;
    repeat (4) expQ.push_back({15'h0101, 1'b0});
    expQ.push_back({15'h0505, 1'b1});
    applyStimulus(5, 5, 5, 5, 1'b1);
    cpuReq = 1'b1;
    gnts = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpuGnt) gnts++;
    end
    cpuReq = 1'b0;
    checkOutput("burst_gnts", 32'(gnts), 4);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (fillDone) seen = 1;
      tick();
    end
    checkOutput("burst_done", {31'h0, seen}, 1);
    checkOutput("burst_q",    32'(expQ.size()), 0);

    // Rejected command, then a legal one that clears the error.
    runFill(9, 3, 0, 0, 1'b1, 20, -1, busyCnt, doneCnt);
    checkOutput("err_busy", 32'(busyCnt), 0);
    checkOutput("err_done", 32'(doneCnt), 1);
    checkOutput("err_flag", {31'h0, fillErr}, 1);
    runFill(0, 0, 0, 120, 1'b1, 20, -1, busyCnt, doneCnt);
    checkOutput("err_y_flag", {31'h0, fillErr}, 1);
    runFill(1, 2, 1, 1, 1'b0, 20, -1, busyCnt, doneCnt);
    checkOutput("err_clear", {31'h0, fillErr}, 0);
    checkOutput("err_clear_busy", 32'(busyCnt), 2);

    // Simultaneous CPU request and fill start in IDLE.
    expQ.push_back({15'h0707, 1'b1});
    pushFill(3, 4, 4, 4, 1'b1, 1 << 30);
    cpuReq = 1'b1; cpuX = 8'd7; cpuY = 7'd7; cpuPixel = 1'b1;
    applyStimulus(3, 4, 4, 4, 1'b1);
    cpuReq = 1'b0;
    checkOutput("simul_gnt",  {31'h0, cpuGnt},   1);
    checkOutput("simul_busy", {31'h0, fillBusy}, 1);
    repeat (6) tick();
    checkOutput("simul_q", 32'(expQ.size()), 0);

    // Full-screen clear with an ignored mid-fill start.
    runFill(0, 159, 0, 119, 1'b0, 19300, 100, busyCnt, doneCnt);
    checkOutput("clear_busy", 32'(busyCnt), 19200);
    checkOutput("clear_done", 32'(doneCnt), 1);
    checkOutput("clear_last", {17'h0, lastAddr}, 32'h779F);
    checkOutput("clear_q",    32'(expQ.size()), 0);
    checkOutput("clear_err",  {31'h0, fillErr}, 0);

    // Reset in the middle of a fill, right after write 50 is seen.
    pushFill(0, 159, 0, 119, 1'b1, 50);
    applyStimulus(0, 159, 0, 119, 1'b1);
    writes = 0;
    for (int c = 0; c < 200 && writes < 50; c++) begin
      if (fbWe) writes++;
      if (writes < 50) tick();
    end
    checkOutput("abort_reach50", 32'(writes), 50);
    resetN = 1'b0;
    tick();
    checkOutput("abort_we",   {31'h0, fbWe},     0);
    checkOutput("abort_busy", {31'h0, fillBusy}, 0);
    tick();
    resetN = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (fillDone || fbWe) seen = 1;
    end
    checkOutput("abort_quiet", {31'h0, seen}, 0);
    checkOutput("abort_q",     32'(expQ.size()), 0);

    cpuReq = 1'b1; cpuX = 8'd200; cpuY = 7'd5; cpuPixel = 1'b1;
    tick();
    cpuReq = 1'b0;
    checkOutput("oob_gnt", {31'h0, cpuGnt}, 1);
    checkOutput("oob_we",  {31'h0, fbWe},   0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns port A (write side) of the 160x120 1-bit frame buffer.
- Shares that port between two requesters: single-pixel writes from the bus peripheral, and an internal rectangle fill/clear engine.
- The fill engine lets software clear the screen or draw boxes without issuing one bus write per pixel.
- Sits between the VGA bus decode logic and Frame_Buffer port A.

Parameters:
- X_MAX, 159, largest legal X coordinate.
- Y_MAX, 119, largest legal Y coordinate.
- CPU_BURST, 4, maximum consecutive CPU grants while a fill is pending; the fill is then guaranteed one slot.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- CPU_REQ  in  1  CPU pixel write request; held high until CPU_GNT.
- CPU_X  in  8  CPU pixel X.
- CPU_Y  in  7  CPU pixel Y.
- CPU_PIXEL  in  1  CPU pixel value.
- CPU_GNT  out  1  one-cycle pulse: CPU write issued this cycle.
- FILL_START  in  1  one-cycle pulse: start a rectangle fill.
- FILL_X0, FILL_X1  in  8  inclusive X bounds.
- FILL_Y0, FILL_Y1  in  7  inclusive Y bounds.
- FILL_PIXEL  in  1  fill value.
- FILL_BUSY  out  1  fill in progress.
- FILL_DONE  out  1  one-cycle pulse at fill completion or rejection.
- FILL_ERR  out  1  sticky: last command was rejected; cleared by the next accepted FILL_START.
- FB_ADDR  out  15  frame buffer address {Y[6:0], X[7:0]}.
- FB_DATA_IN  out  1  frame buffer write data.
- FB_WE  out  1  frame buffer write enable.

Behaviour:
- Reset (RESET==0 at a CLK edge): FB_WE=0, FB_ADDR=0, FB_DATA_IN=0, CPU_GNT=0, FILL_BUSY=0, FILL_DONE=0, FILL_ERR=0, state=IDLE, burst counter=0.
  - Reset mid-fill aborts the fill immediately. No further writes are issued and no FILL_DONE is produced.
- All outputs are registered. A CPU_REQ sampled at edge k gives FB_WE, FB_ADDR and CPU_GNT high after edge k, i.e. 1-cycle latency.
- At most one write per cycle. FB_WE never asserts for out-of-range coordinates.
- CPU path:
  - CPU_X>X_MAX or CPU_Y>Y_MAX: the request is granted (CPU_GNT pulses) but FB_WE stays 0, so the write is dropped.
  - After a grant the CPU must drop CPU_REQ or present a new request. A request still high on the cycle after CPU_GNT is treated as a new write.
- FSM states: IDLE, FILL, DONE.
  - IDLE: FILL_START is latched with all bounds.
    - If X0>X1, Y0>Y1, X1>X_MAX or Y1>Y_MAX: go to DONE, set FILL_ERR, issue no writes.
    - Otherwise: X_CUR=X0, Y_CUR=Y0, FILL_BUSY=1, FILL_ERR=0, go to FILL.
  - FILL: every cycle the fill wins arbitration, write (X_CUR, Y_CUR, FILL_PIXEL) and advance the raster.
    - Scan order: X_CUR increments. At X_CUR==X1, X_CUR returns to X0 and Y_CUR increments.
    - On writing (X1, Y1), go to DONE.
  - DONE: FILL_DONE=1 for one cycle, FILL_BUSY=0, return to IDLE.
- FILL_START while FILL_BUSY=1, or in DONE: ignored. FILL_ERR is not affected.
- Arbitration in FILL:
  - CPU_REQ has priority and the burst counter increments per CPU grant.
  - When the counter reaches CPU_BURST, the next cycle goes to the fill even if CPU_REQ=1, and the counter clears.
  - The counter also clears on any fill slot.
  - In IDLE or DONE the CPU is granted every request.
- Simultaneous FILL_START and CPU_REQ in IDLE: the CPU write issues that cycle and the fill command is latched in the same cycle.
- Write count for a valid command: (X1-X0+1)*(Y1-Y0+1). With no CPU traffic, FILL_BUSY lasts exactly that many cycles.
- Coordinate counters are 8-bit and 7-bit. No wrap occurs because bounds are checked at start.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W=160, FB_H=120;
  - the address-packing function {Y,X};
  - the FSM state enum (IDLE/FILL/DONE).
- One sub-module, fb_rect_scanner: holds the X/Y raster counters, start, advance and last-pixel flag.
- The arbiter, FSM and output registers stay in the top module.

Test Plan:
- Reset then idle: all outputs 0. CPU_REQ with (10,20,1) -> next cycle FB_WE=1, FB_ADDR=0x140A, FB_DATA_IN=1, CPU_GNT=1.
- Fill (0,0)-(2,1), pixel 1, no CPU traffic -> 6 writes at 0x0000, 0x0001, 0x0002, 0x0100, 0x0101, 0x0102; FILL_BUSY high for 6 cycles; FILL_DONE pulses once.
- Fill (5,5)-(5,5) with CPU_REQ held high throughout -> 4 CPU grants, then 1 fill write at 0x0505, then FILL_DONE.
- Fill with X0=9, X1=3 -> zero FB_WE, FILL_DONE pulse, FILL_ERR=1. A following valid fill clears FILL_ERR.
- Full-screen clear (0,0)-(159,119), pixel 0 -> 19200 writes; last write at 0x779F. A second FILL_START mid-fill is ignored.
- RESET low during the fill at write 50 -> FB_WE=0 next cycle, FILL_BUSY=0, no FILL_DONE. CPU write at (200,5) -> CPU_GNT=1, FB_WE=0.
